// File: rtl/m_csr_access_unit.sv
// Zicsr access engine: legality check, then read / write / RMW
// against the CSR file over a req/ack handshake.
module m_csr_access_unit #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 12,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       instruction,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [1:0]        csr_ops,
  input  logic [1:0]        priv_level,
  input  logic              RegWrite_id2exe,
  output logic              csr_rd_req,
  output logic              csr_wr_req,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [XLEN-1:0]   csr_wdata,
  input  logic [XLEN-1:0]   csr_rdata,
  input  logic              csr_ack,
  output logic              done_valid,
  output logic [4:0]        rd_addr,
  output logic [XLEN-1:0]   rd_wdata,
  output logic              RegWrite,
  output logic              illegal_insn,
  output logic              stall
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT);
  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [4:0]         rd_q, rs1f_q;
  logic [1:0]         op_q;
  logic               rw_id_q;
  logic [XLEN-1:0]    opnd_q, old_q;

  logic [ADDR_W-1:0]  in_addr;
  logic [4:0]         in_rd, in_rs1f;
  logic               in_rd_en, in_wr_en, in_fault;
  logic               accept, wr_en_q, expired;
  logic [XLEN-1:0]    in_opnd, wdata_c;
  logic               unused_insn;

  assign in_addr  = instruction[20 +: ADDR_W];
  assign in_rs1f  = instruction[19:15];
  assign in_rd    = instruction[11:7];
  assign in_opnd  = instruction[14] ?
                    {{(XLEN-5){1'b0}}, in_rs1f} : rs1_data;
  assign in_rd_en = (csr_ops == OP_WRITE) ? (in_rd != 5'd0) : 1'b1;
  assign in_wr_en = (csr_ops == OP_WRITE) || (in_rs1f != 5'd0);
  assign in_fault = (in_wr_en && in_addr[11:10] == 2'b11) ||
                    (priv_level < in_addr[9:8]);
  assign unused_insn = ^{instruction[13:12], instruction[6:0]};

  assign accept  = req_valid && (state_q == S_IDLE);
  assign wr_en_q = (op_q == OP_WRITE) || (rs1f_q != 5'd0);
  assign expired = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  always_comb begin
    wdata_c = opnd_q;
    if (op_q == OP_SET)
      wdata_c = old_q | opnd_q;
    else if (op_q != OP_WRITE)
      wdata_c = old_q & ~opnd_q;
  end

  // ack beats timeout when both land in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          unique case (1'b1)
            (csr_ops == OP_NONE):        state_d = S_DONE;
            (csr_ops != OP_NONE) &&
              in_fault:                  state_d = S_ERR;
            (csr_ops != OP_NONE) &&
              !in_fault && in_rd_en:     state_d = S_READ;
            default:                     state_d = S_WRITE;
          endcase
        end
      end
      S_READ: begin
        if (csr_ack)
          state_d = wr_en_q ? S_WRITE : S_DONE;
        else if (expired)
          state_d = S_ERR;
      end
      S_WRITE: begin
        if (csr_ack)
          state_d = S_DONE;
        else if (expired)
          state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rd_q    <= '0;
      rs1f_q  <= '0;
      op_q    <= OP_NONE;
      rw_id_q <= 1'b0;
      opnd_q  <= '0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q == S_READ || state_q == S_WRITE)
        cnt_q <= cnt_q + 1'b1;
      if (accept) begin
        addr_q  <= in_addr;
        rd_q    <= in_rd;
        rs1f_q  <= in_rs1f;
        op_q    <= csr_ops;
        rw_id_q <= RegWrite_id2exe;
        opnd_q  <= in_opnd;
        old_q   <= '0;
      end else if (state_q == S_READ && csr_ack) begin
        old_q <= csr_rdata;
      end
    end
  end

  assign req_ready    = !rst && (state_q == S_IDLE);
  assign csr_rd_req   = !rst && (state_q == S_READ);
  assign csr_wr_req   = !rst && (state_q == S_WRITE);
  assign csr_addr     = rst ? '0 : addr_q;
  assign csr_wdata    = csr_wr_req ? wdata_c : '0;
  assign done_valid   = !rst &&
                        (state_q == S_DONE || state_q == S_ERR);
  assign illegal_insn = !rst && (state_q == S_ERR);
  assign rd_addr      = rst ? '0 : rd_q;
  assign rd_wdata     = (!rst && state_q == S_DONE) ? old_q : '0;
  assign RegWrite     = !rst && (state_q == S_DONE) &&
                        ((op_q == OP_NONE) ? rw_id_q : (rd_q != 5'd0));
  assign stall        = !rst && (state_q == S_READ ||
                        state_q == S_WRITE || state_q == S_ERR);

endmodule

// File: tb/tb_m_csr_access_unit.sv
// Directed bench for m_csr_access_unit with a same-cycle
// ack responder and hand-computed expectations.
module tb_m_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] instruction, rs1_data;
  logic [1:0]  csr_ops, priv_level;
  logic        RegWrite_id2exe;
  logic        csr_rd_req, csr_wr_req;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_ack;
  logic        done_valid;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        RegWrite, illegal_insn, stall;

  always #5 clk = ~clk;

  m_csr_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .instruction(instruction), .rs1_data(rs1_data),
    .csr_ops(csr_ops), .priv_level(priv_level),
    .RegWrite_id2exe(RegWrite_id2exe),
    .csr_rd_req(csr_rd_req), .csr_wr_req(csr_wr_req),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_ack(csr_ack),
    .done_valid(done_valid), .rd_addr(rd_addr),
    .rd_wdata(rd_wdata), .RegWrite(RegWrite),
    .illegal_insn(illegal_insn), .stall(stall)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [11:0] a,
                                     input logic [4:0] s,
                                     input logic imm,
                                     input logic [4:0] rd);
    return {a, s, imm, 2'b01, rd, 7'h73};
  endfunction

  int          lat;
  logic        saw_rd, saw_wr, both, rw, ill;
  logic [31:0] wd, rdw, adr;
  logic [4:0]  rda;

  task automatic run_op(input logic [31:0] insn,
                        input logic [31:0] rs1v,
                        input logic [1:0]  op,
                        input logic [1:0]  priv,
                        input logic        rwid,
                        input logic [31:0] rdata,
                        input logic        ack_en);
    @(negedge clk);
    instruction     = insn;
    rs1_data        = rs1v;
    csr_ops         = op;
    priv_level      = priv;
    RegWrite_id2exe = rwid;
    req_valid       = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 99; saw_rd = 0; saw_wr = 0; both = 0;
    wd = '0; rdw = '0; rw = 0; ill = 0; rda = '0; adr = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (csr_rd_req && csr_wr_req) both = 1'b1;
      if (csr_rd_req) begin
        saw_rd = 1'b1;
        adr = {20'd0, csr_addr};
      end
      if (csr_wr_req) begin
        saw_wr = 1'b1;
        wd = csr_wdata;
      end
      csr_rdata = rdata;
      csr_ack   = ack_en && (csr_rd_req || csr_wr_req);
      if (done_valid) begin
        lat = k;
        rdw = rd_wdata;
        rw  = RegWrite;
        ill = illegal_insn;
        rda = rd_addr;
        break;
      end
    end
    csr_ack = 1'b0;
  endtask

  int late_done;

  initial begin
    rst = 1'b1; req_valid = 0; instruction = '0; rs1_data = '0;
    csr_ops = 2'b00; priv_level = 2'd3; RegWrite_id2exe = 0;
    csr_rdata = '0; csr_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_done", {31'd0, done_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // CSRRW x1, mscratch
    run_op(mk(12'h340, 5'd5, 1'b0, 5'd1), 32'hA5A5_0000,
           2'b01, 2'd3, 1'b0, 32'h1234, 1'b1);
    chk("rw_lat", lat, 3);
    chk("rw_rd", {31'd0, saw_rd}, 1);
    chk("rw_addr", adr, 32'h340);
    chk("rw_wdata", wd, 32'hA5A5_0000);
    chk("rw_rdw", rdw, 32'h1234);
    chk("rw_regw", {31'd0, rw}, 1);
    chk("rw_rda", {27'd0, rda}, 1);
    chk("rw_both", {31'd0, both}, 0);

    // CSRRW x0: write only
    run_op(mk(12'h340, 5'd5, 1'b0, 5'd0), 32'h0000_00AA,
           2'b01, 2'd3, 1'b0, 32'h5555, 1'b1);
    chk("rw0_lat", lat, 2);
    chk("rw0_rd", {31'd0, saw_rd}, 0);
    chk("rw0_wr", {31'd0, saw_wr}, 1);
    chk("rw0_regw", {31'd0, rw}, 0);
    chk("rw0_rdw", rdw, 0);

    // CSRRS x1, cycle, x0: read-only CSR read is legal
    run_op(mk(12'hC00, 5'd0, 1'b0, 5'd1), 32'hFFFF_FFFF,
           2'b10, 2'd3, 1'b0, 32'h0000_0077, 1'b1);
    chk("rs_ro_lat", lat, 2);
    chk("rs_ro_wr", {31'd0, saw_wr}, 0);
    chk("rs_ro_ill", {31'd0, ill}, 0);
    chk("rs_ro_rdw", rdw, 32'h77);

    // CSRRC x1, mstatus, rs1=0x0F, old 0xFF
    run_op(mk(12'h300, 5'd3, 1'b0, 5'd1), 32'h0000_000F,
           2'b11, 2'd3, 1'b0, 32'h0000_00FF, 1'b1);
    chk("rc_lat", lat, 3);
    chk("rc_wdata", wd, 32'hF0);
    chk("rc_rdw", rdw, 32'hFF);

    // CSRRSI x2, zimm=5, old 0x10
    run_op(mk(12'h300, 5'd5, 1'b1, 5'd2), 32'hFFFF_0000,
           2'b10, 2'd3, 1'b0, 32'h0000_0010, 1'b1);
    chk("rsi_wdata", wd, 32'h15);
    chk("rsi_rdw", rdw, 32'h10);
    chk("rsi_rda", {27'd0, rda}, 2);

    // CSRRW to read-only CSR faults
    run_op(mk(12'hC00, 5'd5, 1'b0, 5'd1), 32'h1,
           2'b01, 2'd3, 1'b0, 32'h0, 1'b1);
    chk("ro_lat", lat, 1);
    chk("ro_ill", {31'd0, ill}, 1);
    chk("ro_req", {30'd0, saw_rd, saw_wr}, 0);
    chk("ro_regw", {31'd0, rw}, 0);

    // U-mode touching an M-mode CSR faults
    run_op(mk(12'h300, 5'd0, 1'b0, 5'd1), 32'h0,
           2'b10, 2'd0, 1'b0, 32'h0, 1'b1);
    chk("priv_lat", lat, 1);
    chk("priv_ill", {31'd0, ill}, 1);
    chk("priv_req", {30'd0, saw_rd, saw_wr}, 0);

    // S-mode reading an S-mode CSR is legal
    run_op(mk(12'h100, 5'd0, 1'b0, 5'd4), 32'h0,
           2'b10, 2'd1, 1'b0, 32'hCAFE, 1'b1);
    chk("smode_lat", lat, 2);
    chk("smode_ill", {31'd0, ill}, 0);
    chk("smode_rdw", rdw, 32'hCAFE);

    // NONE op passes decode RegWrite through
    run_op(mk(12'h340, 5'd1, 1'b0, 5'd7), 32'h0,
           2'b00, 2'd0, 1'b1, 32'h0, 1'b1);
    chk("none_lat", lat, 1);
    chk("none_regw", {31'd0, rw}, 1);
    chk("none_rda", {27'd0, rda}, 7);
    chk("none_req", {30'd0, saw_rd, saw_wr}, 0);
    chk("none_ill", {31'd0, ill}, 0);

    // ack never arrives: timeout fault
    run_op(mk(12'h340, 5'd5, 1'b0, 5'd1), 32'h1,
           2'b01, 2'd3, 1'b0, 32'h0, 1'b0);
    chk("to_lat", lat, 17);
    chk("to_ill", {31'd0, ill}, 1);
    chk("to_wr", {31'd0, saw_wr}, 0);
    chk("to_regw", {31'd0, rw}, 0);

    // reset in the middle of a read
    @(negedge clk);
    instruction = mk(12'h340, 5'd5, 1'b0, 5'd1);
    csr_ops = 2'b01; priv_level = 2'd3; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rd_req", {31'd0, csr_rd_req}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_rd", {31'd0, csr_rd_req}, 0);
    chk("mid_rst_done", {31'd0, done_valid}, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk("mid_rst_ready", {31'd0, req_ready}, 1);
    late_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_valid || csr_rd_req || csr_wr_req)
        late_done = 1;
    end
    chk("mid_rst_quiet", late_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
